// File: rtl/window_expander_kxk_pkg.sv
// Shared constants, one-hot state encodings and helpers for window_expander_kxk.
package window_expander_kxk_pkg;

  localparam int WIDTH_DATA  = 8;
  localparam int PICTURE_NUM = 1;

  typedef logic [4:0] state_t;

  localparam state_t S_IDLE      = 5'b00001;
  localparam state_t S_WAIT_ROW  = 5'b00010;
  localparam state_t S_WAIT_FIFO = 5'b00100;
  localparam state_t S_READ      = 5'b01000;
  localparam state_t S_ROW_END   = 5'b10000;

  function automatic int CLOG2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/window_expander_kxk_if.sv
// Tap-bus interface between the expander and the convolution window FIFOs.
// M_Last exists only when WINDOW_EXPANDER_LAST_EN is defined.
interface window_expander_kxk_if #(
  parameter int T  = 9,
  parameter int WD = 128
);
  logic [WD*T-1:0] M_Data;
  logic [T-1:0]    M_EN_Write;
  logic            M_Ready;
`ifdef WINDOW_EXPANDER_LAST_EN
  logic [T-1:0]    M_Last;

  modport master (output M_Data, output M_EN_Write, output M_Last, input M_Ready);
  modport slave  (input M_Data, input M_EN_Write, input M_Last, output M_Ready);
`else
  modport master (output M_Data, output M_EN_Write, input M_Ready);
  modport slave  (input M_Data, input M_EN_Write, output M_Ready);
`endif
endinterface

// File: rtl/window_expander_kxk_tap_enable_gen.sv
// Column enables for one row of taps: tap column c sees column x of the row
// iff c <= x <= N-K+c, and with stride 2 only when (x-c) is even.
module tap_enable_gen #(
  parameter int K = 3,
  parameter int W = 12
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_n,
  input  logic         i_stride2,
  output logic [K-1:0] o_col_en
);
  logic [W-1:0] w_span;

  assign w_span = i_n - W'(K);

  always_comb begin
    o_col_en = '0;
    for (int c = 0; c < K; c++) begin
      o_col_en[c] = (i_x >= W'(c)) && (i_x <= w_span + W'(c)) &&
                    (!i_stride2 || (i_x[0] == c[0]));
    end
  end
endmodule

// File: rtl/window_expander_kxk.sv
// KxK window expander: reads K padded rows word by word and fans each row out to K column taps.
// Optional per-tap frame-end marker M_Last is enabled by defining WINDOW_EXPANDER_LAST_EN.
module window_expander_kxk
  import window_expander_kxk_pkg::*;
#(
  parameter int K                  = 3,
  parameter int CHANNEL_IN_NUM     = 16,
  parameter int WIDTH_RAM_SIZE     = 12,
  parameter int WIDTH_FEATURE_SIZE = 12,
  parameter int WIDTH_CHANNEL_NUM  = 10,
  parameter int RD_LAT             = 1,
  parameter int WD                 = WIDTH_DATA*PICTURE_NUM*CHANNEL_IN_NUM
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          Start,
  input  logic                          Row_Compute_Sign,
  input  logic [WIDTH_FEATURE_SIZE-1:0] Row_Num_After_Padding,
  input  logic [WIDTH_CHANNEL_NUM-1:0]  Channel_In_Num_REG,
  input  logic                          Stride2,
  input  logic [WD*K-1:0]               S_Feature,
  output logic [WIDTH_RAM_SIZE-1:0]     Addr,
  output logic                          S_Ready,
  output logic                          Row_Done,
  output logic                          Frame_Done,
  window_expander_kxk_if.master         m_if
);
  localparam int T         = K*K;
  localparam int CIN_SHIFT = CLOG2(CHANNEL_IN_NUM);

  state_t                          r_state, w_next_state;
  logic                            r_stride2;
  logic [WIDTH_CHANNEL_NUM-1:0]    r_g, w_g_raw, w_g_num, w_g_last;
  logic [WIDTH_FEATURE_SIZE-1:0]   r_x, r_cnt_row, w_n_minus_k, w_r_last;
  logic [WIDTH_RAM_SIZE-1:0]       r_addr;
  logic                            w_in_read, w_g_wrap, w_x_last, w_row_last;
  logic [K-1:0]                    w_col_en;
  logic [T-1:0]                    w_en_issue;
  logic [T-1:0]                    r_en_pipe [RD_LAT];

  assign w_g_raw     = Channel_In_Num_REG >> CIN_SHIFT;
  assign w_g_num     = (w_g_raw == '0) ? WIDTH_CHANNEL_NUM'(1) : w_g_raw;
  assign w_g_last    = w_g_num - WIDTH_CHANNEL_NUM'(1);
  assign w_n_minus_k = Row_Num_After_Padding - WIDTH_FEATURE_SIZE'(K);
  assign w_r_last    = w_n_minus_k >> r_stride2;
  assign w_in_read   = (r_state == S_READ);
  assign w_g_wrap    = (r_g == w_g_last);
  assign w_x_last    = (r_x == Row_Num_After_Padding - WIDTH_FEATURE_SIZE'(1));
  assign w_row_last  = (r_cnt_row == w_r_last);

  // State | meaning
  // IDLE      | waiting for Start
  // WAIT_ROW  | waiting for K rows from the line buffer
  // WAIT_FIFO | waiting for room for a full row downstream
  // READ      | issuing one word address per cycle
  // ROW_END   | row finished; frame ends here on the last output row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (Start)            w_next_state = S_WAIT_ROW;
      S_WAIT_ROW:  if (Row_Compute_Sign) w_next_state = S_WAIT_FIFO;
      S_WAIT_FIFO: if (m_if.M_Ready)     w_next_state = S_READ;
      S_READ:      if (w_x_last && w_g_wrap) w_next_state = S_ROW_END;
      S_ROW_END:   w_next_state = w_row_last ? S_IDLE : S_WAIT_ROW;
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    Addr       = '0;
    Row_Done   = 1'b0;
    Frame_Done = 1'b0;
    case (r_state)
      S_READ:    Addr = r_addr;
      S_ROW_END: begin
        Row_Done   = 1'b1;
        Frame_Done = w_row_last;
      end
      default: ;
    endcase
  end

  // r_addr tracks x*G+g without a multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stride2 <= 1'b0;
      r_g       <= '0;
      r_x       <= '0;
      r_addr    <= '0;
      r_cnt_row <= '0;
      S_Ready   <= 1'b0;
    end else begin
      S_Ready <= (w_next_state == S_WAIT_FIFO) || (w_next_state == S_READ) ||
                 (w_next_state == S_ROW_END);
      if (r_state == S_IDLE && Start) r_stride2 <= Stride2;
      if (w_in_read) begin
        r_addr <= r_addr + WIDTH_RAM_SIZE'(1);
        if (w_g_wrap) begin
          r_g <= '0;
          r_x <= r_x + WIDTH_FEATURE_SIZE'(1);
        end else begin
          r_g <= r_g + WIDTH_CHANNEL_NUM'(1);
        end
      end else begin
        r_addr <= '0;
        r_g    <= '0;
        r_x    <= '0;
      end
      if (r_state == S_IDLE)         r_cnt_row <= '0;
      else if (r_state == S_ROW_END) r_cnt_row <= r_cnt_row + WIDTH_FEATURE_SIZE'(1);
    end
  end

  tap_enable_gen #(.K(K), .W(WIDTH_FEATURE_SIZE)) u_tap_enable_gen (
    .i_x       (r_x),
    .i_n       (Row_Num_After_Padding),
    .i_stride2 (r_stride2),
    .o_col_en  (w_col_en)
  );

  for (genvar r = 0; r < K; r++) begin : g_row
    assign w_en_issue[r*K +: K] = w_in_read ? w_col_en : '0;
    for (genvar c = 0; c < K; c++) begin : g_col
      assign m_if.M_Data[(r*K+c)*WD +: WD] = S_Feature[r*WD +: WD];
    end
  end

  // Enables travel with the read so they meet the returning S_Feature word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_en_pipe[i] <= '0;
    end else begin
      r_en_pipe[0] <= w_en_issue;
      for (int i = 1; i < RD_LAT; i++) r_en_pipe[i] <= r_en_pipe[i-1];
    end
  end

  assign m_if.M_EN_Write = r_en_pipe[RD_LAT-1];

`ifdef WINDOW_EXPANDER_LAST_EN
  logic [WIDTH_FEATURE_SIZE-1:0] w_last_span;
  logic [K-1:0]                  w_col_last;
  logic [T-1:0]                  w_last_issue;
  logic [T-1:0]                  r_last_pipe [RD_LAT];

  // Largest x-c that is still enabled: N-K, rounded down to even for stride 2
  assign w_last_span = r_stride2 ? {w_n_minus_k[WIDTH_FEATURE_SIZE-1:1], 1'b0} : w_n_minus_k;

  for (genvar c = 0; c < K; c++) begin : g_last_col
    assign w_col_last[c] = w_col_en[c] && (r_x == w_last_span + WIDTH_FEATURE_SIZE'(c));
  end

  for (genvar r = 0; r < K; r++) begin : g_last_row
    assign w_last_issue[r*K +: K] = (w_in_read && w_row_last && w_g_wrap) ? w_col_last : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_last_pipe[i] <= '0;
    end else begin
      r_last_pipe[0] <= w_last_issue;
      for (int i = 1; i < RD_LAT; i++) r_last_pipe[i] <= r_last_pipe[i-1];
    end
  end

  assign m_if.M_Last = r_last_pipe[RD_LAT-1];
`endif

endmodule

// File: tb/tb_window_expander_kxk.sv
// Bench for window_expander_kxk: one RD_LAT=1 and one RD_LAT=3 instance on shared stimulus,
// table of frame configurations with hand-derived tap masks, plus stall and reset sequences.
`timescale 1ns/1ps
module tb_window_expander_kxk;
  import window_expander_kxk_pkg::*;

  localparam int K  = 3;
  localparam int T  = K*K;
  localparam int WD = WIDTH_DATA*PICTURE_NUM*16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              Start = 1'b0;
  logic              Row_Compute_Sign = 1'b0;
  logic              Stride2 = 1'b0;
  logic              m_ready = 1'b0;
  logic [11:0]       Row_Num_After_Padding = 12'd6;
  logic [9:0]        Channel_In_Num_REG = 10'd16;
  logic [WD*K-1:0]   S_Feature = '0;
  logic [11:0]       addr1, addr3;
  logic              s_ready1, s_ready3, row_done1, row_done3, frame_done1, frame_done3;

  window_expander_kxk_if #(.T(T), .WD(WD)) if1 ();
  window_expander_kxk_if #(.T(T), .WD(WD)) if3 ();
  assign if1.M_Ready = m_ready;
  assign if3.M_Ready = m_ready;

  always #5 clk = ~clk;

  window_expander_kxk #(.K(K), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Row_Compute_Sign(Row_Compute_Sign),
    .Row_Num_After_Padding(Row_Num_After_Padding), .Channel_In_Num_REG(Channel_In_Num_REG),
    .Stride2(Stride2), .S_Feature(S_Feature), .Addr(addr1), .S_Ready(s_ready1),
    .Row_Done(row_done1), .Frame_Done(frame_done1), .m_if(if1));

  window_expander_kxk #(.K(K), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Row_Compute_Sign(Row_Compute_Sign),
    .Row_Num_After_Padding(Row_Num_After_Padding), .Channel_In_Num_REG(Channel_In_Num_REG),
    .Stride2(Stride2), .S_Feature(S_Feature), .Addr(addr3), .S_Ready(s_ready3),
    .Row_Done(row_done3), .Frame_Done(frame_done3), .m_if(if3));

  typedef struct { int n; int cin; int g; bit s2; int rows; logic [71:0] m; } vec_t;
  typedef struct { int due; logic [8:0] en; } exp_t;

  vec_t vec [5];
  exp_t q1 [$];
  exp_t q3 [$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int n, input int cin, input int g, input bit s2,
                              input int rows, input logic [71:0] m);
    vec_t v;
    v.n = n; v.cin = cin; v.g = g; v.s2 = s2; v.rows = rows; v.m = m;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] due_mask(input bit slow, input int k);
    logic [8:0] e;
    exp_t x;
    e = '0;
    if (!slow) begin
      if (q1.size() > 0 && q1[0].due == k) begin x = q1.pop_front(); e = x.en; end
    end else begin
      if (q3.size() > 0 && q3[0].due == k) begin x = q3.pop_front(); e = x.en; end
    end
    return e;
  endfunction

  // Starts from WAIT_ROW (or earlier), runs one output row and its RD_LAT=3 tail.
  task automatic run_row(input int ti, input int stall, input bit last, input bit poke_start);
    int n, g, nr;
    logic [8:0] m, e;
    n = vec[ti].n; g = vec[ti].g; nr = n*g;
    Row_Compute_Sign = 1'b1;
    tick();
    Row_Compute_Sign = 1'b0;
    chk("s_ready_wait_fifo", 64'(s_ready1), 64'd1);
    for (int i = 0; i < stall; i++) begin
      chk($sformatf("stall_s_ready i=%0d", i), 64'(s_ready1), 64'd1);
      chk($sformatf("stall_addr i=%0d", i), 64'(addr1), 64'd0);
      chk($sformatf("stall_en1 i=%0d", i), 64'(if1.M_EN_Write), 64'd0);
      chk($sformatf("stall_en3 i=%0d", i), 64'(if3.M_EN_Write), 64'd0);
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    for (int k = 0; k < nr + 3; k++) begin
      Start = (poke_start && k == 1);
      if (k < nr) begin
        chk($sformatf("addr1 t%0d k=%0d", ti, k), 64'(addr1), 64'(k));
        chk($sformatf("addr3 t%0d k=%0d", ti, k), 64'(addr3), 64'(k));
        m = vec[ti].m[(k/g)*9 +: 9];
        q1.push_back('{k + 1, m});
        q3.push_back('{k + 3, m});
      end else begin
        chk($sformatf("addr_idle t%0d k=%0d", ti, k), 64'(addr1), 64'd0);
      end
      e = due_mask(1'b0, k);
      chk($sformatf("en1 t%0d k=%0d", ti, k), 64'(if1.M_EN_Write), 64'(e));
      e = due_mask(1'b1, k);
      chk($sformatf("en3 t%0d k=%0d", ti, k), 64'(if3.M_EN_Write), 64'(e));
      chk($sformatf("row_done1 t%0d k=%0d", ti, k), 64'(row_done1), 64'(k == nr));
      chk($sformatf("row_done3 t%0d k=%0d", ti, k), 64'(row_done3), 64'(k == nr));
      chk($sformatf("frame_done1 t%0d k=%0d", ti, k), 64'(frame_done1), 64'(k == nr && last));
      chk($sformatf("frame_done3 t%0d k=%0d", ti, k), 64'(frame_done3), 64'(k == nr && last));
      chk($sformatf("s_ready1 t%0d k=%0d", ti, k), 64'(s_ready1), 64'(k <= nr));
      tick();
    end
    Start = 1'b0;
  endtask

  task automatic run_frame(input int ti, input int stall);
    Row_Num_After_Padding = 12'(vec[ti].n);
    Channel_In_Num_REG    = 10'(vec[ti].cin);
    Stride2 = vec[ti].s2;
    Start   = 1'b1;
    tick();
    Start   = 1'b0;
    Stride2 = ~vec[ti].s2;
    for (int r = 0; r < vec[ti].rows; r++)
      run_row(ti, (r == 0) ? stall : 0, r == vec[ti].rows - 1, r == 1);
    // A finished frame must sit in IDLE and ignore Row_Compute_Sign
    Row_Compute_Sign = 1'b1;
    tick();
    tick();
    chk($sformatf("idle_after_frame t%0d", ti), 64'(s_ready1), 64'd0);
    chk($sformatf("idle_after_frame3 t%0d", ti), 64'(s_ready3), 64'd0);
    Row_Compute_Sign = 1'b0;
    tick();
  endtask

  initial begin
    logic [WD*T-1:0] exp_data;

    vec[0] = mk(6, 16, 1, 1'b0, 4, {9'h000, 9'h000, 9'h124, 9'h1B6, 9'h1FF, 9'h1FF, 9'h0DB, 9'h049});
    vec[1] = mk(6, 16, 1, 1'b1, 2, {9'h000, 9'h000, 9'h000, 9'h124, 9'h092, 9'h16D, 9'h092, 9'h049});
    vec[2] = mk(5, 48, 3, 1'b0, 3, {9'h000, 9'h000, 9'h000, 9'h124, 9'h1B6, 9'h1FF, 9'h0DB, 9'h049});
    vec[3] = mk(3, 0,  1, 1'b0, 1, {9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h124, 9'h092, 9'h049});
    vec[4] = mk(7, 32, 2, 1'b1, 3, {9'h000, 9'h124, 9'h092, 9'h16D, 9'h092, 9'h16D, 9'h092, 9'h049});

    #2;
    chk("rst_addr", 64'(addr1), 64'd0);
    chk("rst_s_ready", 64'(s_ready1), 64'd0);
    chk("rst_en1", 64'(if1.M_EN_Write), 64'd0);
    chk("rst_en3", 64'(if3.M_EN_Write), 64'd0);
    chk("rst_row_done", 64'(row_done1), 64'd0);
    chk("rst_frame_done", 64'(frame_done1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 2; t++) begin
      for (int w = 0; w < WD*K/32; w++) S_Feature[w*32 +: 32] = $urandom();
      #1;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) exp_data[(r*K+c)*WD +: WD] = S_Feature[r*WD +: WD];
      n_vec++;
      if (if1.M_Data !== exp_data) begin
        n_bad++;
        $display("FAIL m_data t=%0d: got %0h expected %0h", t, if1.M_Data[WD-1:0], exp_data[WD-1:0]);
      end
    end
    S_Feature = '0;

    run_frame(0, 10);
    for (int ti = 1; ti < 5; ti++) run_frame(ti, 0);

    // Reset in the middle of READ at x=2
    Row_Num_After_Padding = 12'd6;
    Channel_In_Num_REG    = 10'd16;
    Stride2 = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Row_Compute_Sign = 1'b1;
    tick();
    Row_Compute_Sign = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    tick();
    chk("pre_reset_addr", 64'(addr1), 64'd2);
    chk("pre_reset_en1", 64'(if1.M_EN_Write), 64'h0DB);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_addr1", 64'(addr1), 64'd0);
    chk("mid_reset_addr3", 64'(addr3), 64'd0);
    chk("mid_reset_en1", 64'(if1.M_EN_Write), 64'd0);
    chk("mid_reset_en3", 64'(if3.M_EN_Write), 64'd0);
    chk("mid_reset_s_ready", 64'(s_ready1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q1.delete();
    q3.delete();
    tick();
    tick();
    chk("post_reset_s_ready", 64'(s_ready1), 64'd0);
    chk("post_reset_addr", 64'(addr1), 64'd0);
    chk("post_reset_en3", 64'(if3.M_EN_Write), 64'd0);
    run_frame(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/window_expander_kxk.md
Name: window_expander_kxk

Overview:
- Successor of the fixed 3-row to 9-tap expander.
- Takes K padded feature rows in parallel from the row line-buffer and replicates each row onto K column taps, giving a KxK tap bus for the convolution window FIFOs.
- Generalised over kernel size, channel-group width and RAM read latency.
- Adds stride-2 column decimation, a stride-aware last-row test, a row-done pulse and a frame-done pulse.

Parameters:
- K, 3: kernel size (3..7); tap count T = K*K.
- CHANNEL_IN_NUM, 16: channels per RAM word (power of 2); CIN_SHIFT = log2(CHANNEL_IN_NUM).
- WIDTH_RAM_SIZE, 12: line-buffer address width.
- WIDTH_FEATURE_SIZE, 12: row/column counter width.
- WIDTH_CHANNEL_NUM, 10: channel-count width.
- RD_LAT, 1: line-buffer read latency in cycles (1..3).
- WD, `WIDTH_DATA*`PICTURE_NUM*CHANNEL_IN_NUM: one row slice width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  frame start pulse.
- Row_Compute_Sign  in  1  upstream has K rows ready.
- Row_Num_After_Padding  in  WIDTH_FEATURE_SIZE  padded row length N (N>=K).
- Channel_In_Num_REG  in  WIDTH_CHANNEL_NUM  input channels (multiple of CHANNEL_IN_NUM).
- Stride2  in  1  0 = stride 1, 1 = stride 2; sampled on Start.
- S_Feature  in  WD*K  K row slices, row r at [(r+1)*WD-1:r*WD].
- Addr  out  WIDTH_RAM_SIZE  line-buffer read address.
- S_Ready  out  1  reading/accepting upstream rows.
- M_Ready  in  1  window FIFOs can accept a full row.
- M_Data  out  WD*T  tap (r,c), index r*K+c, carries row slice r.
- M_EN_Write  out  T  per-tap write enable, aligned to S_Feature.
- Row_Done  out  1  one-cycle pulse after the last read of an output row.
- Frame_Done  out  1  one-cycle pulse when the last output row completes.

Behaviour:
- Reset values (async on rst_n low): all outputs 0; FSM in IDLE; all counters 0.
- Derived values:
  - G = Channel_In_Num_REG >> CIN_SHIFT, treated as 1 if 0.
  - R_LAST = (N-K) >> Stride2; the output row count is R_LAST+1.
- FSM states:
  - IDLE: on Start, latch Stride2 and go to WAIT_ROW.
  - WAIT_ROW: on Row_Compute_Sign go to WAIT_FIFO.
  - WAIT_FIFO: on M_Ready go to READ.
  - READ: on the last column (x==N-1) with the last group (g==G-1) go to ROW_END.
  - ROW_END: if Cnt_Row==R_LAST go to IDLE and pulse Frame_Done; else go to WAIT_ROW.
  - Row_Done pulses in the ROW_END cycle.
- Counters in READ:
  - g increments each cycle and wraps at G-1.
  - x increments when g wraps.
  - Cnt_Row increments in ROW_END and clears in IDLE.
  - M_Ready is not re-checked mid-row.
- Addr:
  - Reads one word per READ cycle: Addr = x*G+g, incrementing by 1 per READ cycle.
  - Addr is 0 outside READ.
  - The row issues N*G addresses.
- Tap enable:
  - Tap (r,c) is enabled for a read at column x iff c <= x <= N-K+c and (Stride2==0 or (x-c) is even).
  - The condition is identical across r.
  - The enable is computed at address issue, delayed through an RD_LAT-stage pipeline, and lands in the same cycle as the returned S_Feature.
  - The pipeline flushes to 0 naturally after READ, since no new enables are issued.
- M_Data is combinational replication of S_Feature with no register.
- S_Ready is registered from Next_State: 1 for WAIT_FIFO/READ/ROW_END, 0 otherwise.
- Boundary cases:
  - N==K: each tap is enabled exactly once per row group.
  - Start is ignored outside IDLE.
  - A reset mid-row drops the in-flight enables immediately.
  - Odd (N-K) with Stride2: the last column is dropped, per the floor in R_LAST.

Optional Feature:
- Macro: WINDOW_EXPANDER_LAST_EN.
- When defined: adds output M_Last (width T). Each bit asserts together with M_EN_Write on that tap's final write of the frame (last row, largest enabled x, g==G-1). This lets downstream FIFOs close the frame.
- When undefined: the port is absent and the logic is removed.

Decomposition:
- Shared package (Para.v additions): WIDTH_DATA, PICTURE_NUM, the state encodings as one-hot localparams, and the CLOG2 function used to derive CIN_SHIFT.
- One sub-module, tap_enable_gen: given x, N, Stride2 and K, it outputs the K column enables. It is replicated across rows by wiring, not by instance.

Test Plan:
- K=3, N=6, G=1, stride1, RD_LAT=1:
  - Enable masks by x=0..5 are 0x049, 0x0DB, 0x1FF, 0x1FF, 0x1B6, 0x124.
  - 4 output rows; Frame_Done after row 3.
- Same with Stride2=1: masks for x=0..5 are 0x049, 0x092, 0x16D, 0x092, 0x124, 0x000; R_LAST=1, so 2 rows.
- K=3, N=5, Channel_In_Num_REG=48 (G=3):
  - Addr runs 0..14 per row.
  - Enables repeat for 3 consecutive cycles per x.
  - Row_Done occurs once per row.
- RD_LAT=3: M_EN_Write trails the first Addr by exactly 3 cycles; the last enable occurs 3 cycles after READ exits.
- Hold M_Ready=0 for 10 cycles in WAIT_FIFO: S_Ready stays 1, Addr stays 0, no enables. After release, the normal row follows.
- Pull rst_n low mid-READ (x=2): all outputs are 0 immediately; after release the FSM is in IDLE, and a new Start restarts from row 0.
